// File: rtl/tsbus_nibble_rx.sv
// tsbus_nibble_rx: receiver for the shared 4-bit tristate nibble bus.
// Samples and acknowledges nibbles, assembles four of them LSB-first into a
// 16-bit word, and presents the word on a valid/ready interface. While a
// word is held, bus_ack is withheld so the transmitter keeps its nibble driven.
// Optional feature: define TSBUS_RX_PARITY_EN to append and check an XOR
// parity nibble (5-nibble frames, par_err on mismatch).
module tsbus_nibble_rx #(
  parameter int unsigned GAP_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  bus_d,
  input  logic        bus_stb,
  output logic        bus_ack,
  output logic [15:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_err,
  output logic        par_err
);

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned GAP_W  = 8;

  // Index of the final nibble of a frame (parity nibble when enabled).
`ifdef TSBUS_RX_PARITY_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(4);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(3);
`endif

  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [GAP_W-1:0]    r_gap;
  logic [GAP_W-1:0]    w_gap_nxt;
  logic [GAP_W-1:0]    w_gap_inc;
  logic [WORD_W-1:0]   r_acc;
  logic [WORD_W-1:0]   w_acc_nxt;
  logic [WORD_W-1:0]   w_acc_ins;
  logic [WORD_W-1:0]   r_word_data;
  logic [WORD_W-1:0]   w_data_nxt;
  logic                r_word_valid;
  logic                w_valid_nxt;
  logic                r_ack;
  logic                w_ack_nxt;
  logic                r_ferr;
  logic                w_ferr_nxt;
`ifdef TSBUS_RX_PARITY_EN
  logic                r_perr;
  logic                w_perr_nxt;
  logic [NIB_W-1:0]    w_par;
`endif

  assign w_gap_inc = r_gap + GAP_W'(1);

`ifdef TSBUS_RX_PARITY_EN
  // Expected parity nibble: XOR of the four collected data nibbles.
  assign w_par = r_acc[3:0] ^ r_acc[7:4] ^ r_acc[11:8] ^ r_acc[15:12];
`endif

  // Accumulator with the current bus nibble written into slot r_cnt.
  always_comb begin
    w_acc_ins = r_acc;
    case (r_cnt)
      CNT_W'(0): w_acc_ins[3:0]   = bus_d;
      CNT_W'(1): w_acc_ins[7:4]   = bus_d;
      CNT_W'(2): w_acc_ins[11:8]  = bus_d;
      CNT_W'(3): w_acc_ins[15:12] = bus_d;
      default:   w_acc_ins        = r_acc;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_acc_nxt   = r_acc;
    w_data_nxt  = r_word_data;
    w_valid_nxt = r_word_valid;
    w_ack_nxt   = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef TSBUS_RX_PARITY_EN
    w_perr_nxt  = 1'b0;
`endif
    unique case (r_state)
      S_IDLE, S_COLLECT: begin
        if (bus_stb) begin
          w_ack_nxt = 1'b1;
          w_gap_nxt = '0;
          w_acc_nxt = w_acc_ins;
          if (r_cnt == LAST_CNT) begin
            w_cnt_nxt = '0;
`ifdef TSBUS_RX_PARITY_EN
            if (bus_d == w_par) begin
              w_state_nxt = S_HOLD;
              w_data_nxt  = r_acc;
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
              w_perr_nxt  = 1'b1;
              w_acc_nxt   = '0;
            end
`else
            w_state_nxt = S_HOLD;
            w_data_nxt  = w_acc_ins;
            w_valid_nxt = 1'b1;
`endif
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = S_COLLECT;
          end
        end else if (r_state == S_COLLECT) begin
          // Idle cycle inside a frame: abort once the gap limit is reached.
          if (w_gap_inc == GAP_LIM) begin
            w_ferr_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_gap_nxt   = '0;
            w_acc_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_gap_nxt = w_gap_inc;
          end
        end
      end
      S_HOLD: begin
        // Strobes are ignored here; a strobe in the handshake cycle waits.
        if (r_word_valid && word_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_gap_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_gap        <= '0;
      r_acc        <= '0;
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
      r_ack        <= 1'b0;
      r_ferr       <= 1'b0;
`ifdef TSBUS_RX_PARITY_EN
      r_perr       <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gap        <= w_gap_nxt;
      r_acc        <= w_acc_nxt;
      r_word_data  <= w_data_nxt;
      r_word_valid <= w_valid_nxt;
      r_ack        <= w_ack_nxt;
      r_ferr       <= w_ferr_nxt;
`ifdef TSBUS_RX_PARITY_EN
      r_perr       <= w_perr_nxt;
`endif
    end
  end

  assign bus_ack    = r_ack;
  assign word_data  = r_word_data;
  assign word_valid = r_word_valid;
  assign frame_err  = r_ferr;
`ifdef TSBUS_RX_PARITY_EN
  assign par_err    = r_perr;
`else
  assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_tsbus_nibble_rx.sv
// Testbench for tsbus_nibble_rx: table of per-cycle vectors plus a hand-written
// asynchronous-reset sequence. Honours TSBUS_RX_PARITY_EN if defined.
module tb_tsbus_nibble_rx;

`ifdef TSBUS_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  bus_d;
  logic        bus_stb;
  logic        bus_ack;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        frame_err;
  logic        par_err;

  tsbus_nibble_rx #(.GAP_MAX(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_d      (bus_d),
    .bus_stb    (bus_stb),
    .bus_ack    (bus_ack),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frame_err  (frame_err),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stb;
    logic [3:0]  d;
    logic        rdy;
    logic        ack;
    logic        valid;
    logic [15:0] data;
    logic        ferr;
    logic        perr;
  } vec_t;

  vec_t vq[$];
  int   n_vec;
  int   n_err;

  function automatic void push(input logic stb, input logic [3:0] d, input logic rdy,
                               input logic ack, input logic valid, input logic [15:0] data,
                               input logic ferr, input logic perr);
    vec_t v;
    v.stb = stb; v.d = d; v.rdy = rdy;
    v.ack = ack; v.valid = valid; v.data = data; v.ferr = ferr; v.perr = perr;
    vq.push_back(v);
  endfunction

  task automatic drive_cycle(input logic stb, input logic [3:0] d, input logic rdy);
    @(negedge clk);
    bus_stb    = stb;
    bus_d      = d;
    word_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ack, input logic valid,
                       input logic [15:0] data, input logic ferr, input logic perr);
    n_vec++;
    if (bus_ack !== ack || word_valid !== valid || word_data !== data ||
        frame_err !== ferr || par_err !== perr) begin
      n_err++;
      $display("FAIL %s: got ack=%0b valid=%0b data=%h ferr=%0b perr=%0b, want ack=%0b valid=%0b data=%h ferr=%0b perr=%0b",
               name, bus_ack, word_valid, word_data, frame_err, par_err,
               ack, valid, data, ferr, perr);
    end
  endtask

  logic [3:0] cafe [4];

  initial begin
    clk = 1'b0; rst_n = 1'b0; bus_stb = 1'b0; bus_d = 4'h0; word_ready = 1'b0;
    n_vec = 0; n_err = 0;
    cafe[0] = 4'hE; cafe[1] = 4'hF; cafe[2] = 4'hA; cafe[3] = 4'hC;

    // Basic frame 16'h4321, back-to-back strobes (parity 4'h4).
    push(1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    push(1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    push(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    push(1'b1, 4'h4, 1'b0, 1'b1, !PAR, PAR ? 16'h0000 : 16'h4321, 1'b0, 1'b0);
    if (PAR) push(1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 16'h4321, 1'b0, 1'b0);
    push(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h4321, 1'b0, 1'b0);
    push(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h4321, 1'b0, 1'b0);

    // Backpressure: 16'hBEEF held while 4'hA is strobed (parity 4'h4).
    push(1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 16'h4321, 1'b0, 1'b0);
    push(1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 16'h4321, 1'b0, 1'b0);
    push(1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 16'h4321, 1'b0, 1'b0);
    push(1'b1, 4'hB, 1'b0, 1'b1, !PAR, PAR ? 16'h4321 : 16'hBEEF, 1'b0, 1'b0);
    if (PAR) push(1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) push(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    push(1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    push(1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    push(1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    push(1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    push(1'b1, 4'h7, 1'b0, 1'b1, !PAR, PAR ? 16'hBEEF : 16'h765A, 1'b0, 1'b0);
    if (PAR) push(1'b1, 4'hE, 1'b0, 1'b1, 1'b1, 16'h765A, 1'b0, 1'b0);
    push(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h765A, 1'b0, 1'b0);

    // Gap abort after 2 nibbles and 8 idle cycles, then 16'h1234 (parity 4'h4).
    push(1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 16'h765A, 1'b0, 1'b0);
    push(1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 16'h765A, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) push(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h765A, 1'b0, 1'b0);
    push(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h765A, 1'b1, 1'b0);
    push(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h765A, 1'b0, 1'b0);
    push(1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 16'h765A, 1'b0, 1'b0);
    push(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 16'h765A, 1'b0, 1'b0);
    push(1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 16'h765A, 1'b0, 1'b0);
    push(1'b1, 4'h1, 1'b0, 1'b1, !PAR, PAR ? 16'h765A : 16'h1234, 1'b0, 1'b0);
    if (PAR) push(1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    push(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0);

    // Seven idle cycles between every nibble of 16'hCAFE (parity 4'h7).
    for (int k = 0; k < 4; k++) begin
      push(1'b1, cafe[k], 1'b0, 1'b1, (k == 3) && !PAR,
           ((k == 3) && !PAR) ? 16'hCAFE : 16'h1234, 1'b0, 1'b0);
      if (k < 3 || PAR)
        for (int i = 0; i < 7; i++) push(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0);
    end
    if (PAR) push(1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 16'hCAFE, 1'b0, 1'b0);
    push(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'hCAFE, 1'b0, 1'b0);

    // Parity mismatch: 16'h1234 followed by 4'h5 instead of 4'h4.
    if (PAR) begin
      push(1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 16'hCAFE, 1'b0, 1'b0);
      push(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 16'hCAFE, 1'b0, 1'b0);
      push(1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 16'hCAFE, 1'b0, 1'b0);
      push(1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 16'hCAFE, 1'b0, 1'b0);
      push(1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 16'hCAFE, 1'b0, 1'b1);
      push(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'hCAFE, 1'b0, 1'b0);
    end

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive_cycle(vq[i].stb, vq[i].d, vq[i].rdy);
      check($sformatf("vec%0d", i), vq[i].ack, vq[i].valid, vq[i].data, vq[i].ferr, vq[i].perr);
    end

    // Asynchronous reset after 3 nibbles, then frame 16'h00F0 (parity 4'hF).
    drive_cycle(1'b1, 4'h5, 1'b0);
    drive_cycle(1'b1, 4'h6, 1'b0);
    drive_cycle(1'b1, 4'h7, 1'b0);
    check("pre_rst", 1'b1, 1'b0, 16'hCAFE, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    bus_stb = 1'b0;
    rst_n   = 1'b1;
    drive_cycle(1'b1, 4'h0, 1'b0);
    drive_cycle(1'b1, 4'hF, 1'b0);
    drive_cycle(1'b1, 4'h0, 1'b0);
    check("post_rst_n2", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'h0, 1'b0);
    if (PAR) drive_cycle(1'b1, 4'hF, 1'b0);
    check("rx_00F0", 1'b1, 1'b1, 16'h00F0, 1'b0, 1'b0);
    drive_cycle(1'b0, 4'h0, 1'b1);
    check("rx_00F0_hs", 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tsbus_nibble_rx.md
# tsbus_nibble_rx

Receiving end of the shared 4-bit tristate nibble bus. A transmitter enables its tristate driver and asserts `bus_stb`. This block samples each nibble and acknowledges it, assembles four nibbles LSB-first into a 16-bit word, and presents the word on a valid/ready interface. It sits between the shared bus and the local consumer, and applies backpressure to the bus by withholding `bus_ack`.

## Interface
- `GAP_MAX`, default 8: maximum consecutive idle cycles (`bus_stb`=0) allowed inside a frame before it is aborted; range 1..255.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `bus_d` input 4: shared tristate bus data; sampled only when `bus_stb`=1.
- `bus_stb` input 1: transmitter strobe; the board pulls it low when no driver is enabled.
- `bus_ack` output 1: registered one-cycle acknowledge per accepted nibble.
- `word_data` output 16: assembled word; stable while `word_valid`=1.
- `word_valid` output 1: a word is available.
- `word_ready` input 1: consumer accepts the word.
- `frame_err` output 1: one-cycle pulse when a frame is aborted on gap timeout.
- `par_err` output 1: one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.

## Operation
- **States**
  - IDLE: no frame in progress.
  - COLLECT: frame in progress; nibble counter `cnt` (0..3, or 0..4 with parity) and gap counter `gap`.
  - HOLD: word presented to the consumer.
- **Accept rule:** in IDLE or COLLECT, `bus_stb`=1 captures `bus_d` into slot `cnt`.
  - Nibble 0 goes to `[3:0]`, nibble 1 to `[7:4]`, and so on.
  - `cnt` increments, `gap` clears, and `bus_ack`=1 the next cycle.
- IDLE → COLLECT on the first accepted nibble.
- COLLECT → HOLD on the last data nibble; with parity, on the parity nibble after a good check.
- **Gap handling:** in COLLECT, each cycle with `bus_stb`=0 increments `gap`.
  - When `gap` reaches `GAP_MAX`: `frame_err` pulses, partial data is discarded, `cnt` clears, and the state returns to IDLE.
- **HOLD:** `bus_stb` is ignored and `bus_ack` stays 0, so the transmitter keeps its nibble driven.
  - HOLD → IDLE on a cycle with `word_valid`=1 and `word_ready`=1.
  - A strobe in that same cycle is not captured; it is captured the following cycle.
- `word_data` is loaded only on entry to HOLD; it holds its value in IDLE and COLLECT.
- The transmitter must not change `bus_d` while `bus_stb`=1 until it sees `bus_ack`. The receiver does not check this.
- **Reset:** asynchronous assertion at any point, including mid-frame or in HOLD, forces IDLE and drops the partial frame.
  - Reset values: `cnt`=0, `gap`=0, `bus_ack`=0, `word_valid`=0, `word_data`=16'h0000, `frame_err`=0, `par_err`=0.

## Timing
- `bus_ack`: 1 cycle after the sampling edge; a 1-cycle pulse per nibble.
- **Back-to-back:** a strobe held high across consecutive cycles is accepted every cycle, and acks are produced every cycle.
- `word_valid` rises 1 cycle after the edge that samples the final nibble.
- **Minimum frame-to-word latency:** 4 cycles from first strobe to `word_valid`; 5 with parity.
- `word_valid` drops the cycle after the handshake. The earliest next nibble capture is that same cycle.
- **Gap timeout:** `frame_err` is asserted on the cycle after the `GAP_MAX`-th consecutive idle cycle within COLLECT.
- No combinational path from any input to any output.

## Configuration
- **`TSBUS_RX_PARITY_EN` defined**
  - Frames are 5 nibbles; nibble 4 = `d[3:0]^d[7:4]^d[11:8]^d[15:12]`.
  - The parity nibble is acknowledged like a data nibble.
  - On mismatch: `par_err` pulses 1 cycle after the parity nibble is sampled, the word is discarded (no `word_valid`), and the state returns to IDLE.
- **Undefined:** frames are 4 nibbles, `par_err` is constant 0, and no parity logic is generated.

## Test plan
- **Basic frame:** reset, then 4 back-to-back strobes with nibbles 4'h1, 4'h2, 4'h3, 4'h4 → `word_data`=16'h4321; `word_valid` 1 cycle after the last sample; 4 `bus_ack` pulses.
- **Backpressure:**
  - Frame 16'hBEEF with `word_ready` held 0 for 10 cycles while the next nibble 4'hA is strobed → no `bus_ack`, `word_data` stable.
  - `word_ready`=1 → 4'hA is acked the cycle after `word_valid` drops.
- **Gap abort:** with `GAP_MAX`=8, send 2 nibbles then 8 idle cycles → `frame_err` pulses once.
  - Next frame 16'h1234 assembles correctly with no residue.
- **Gap below limit:** 7 idle cycles between every nibble of 16'hCAFE → no `frame_err`; `word_data`=16'hCAFE.
- **Reset mid-frame:** `rst_n` low after 3 nibbles → all outputs at reset values immediately.
  - After release, frame 16'h00F0 is received correctly.
- **Parity (`TSBUS_RX_PARITY_EN`):**
  - Frame 16'h1234 with parity 4'h4 → valid word.
  - Same frame with parity 4'h5 → `par_err` pulse, no `word_valid`.
